// File: rtl/lut_bram_arb_pkg.sv
// lut_bram_arb_pkg: shared constants and types for the label-LUT BRAM arbiter.
//   State encoding (one-hot): IDLE, WR_HOLD, RD_WAIT.
//   Read-pipeline source tags: SRC_LU (datapath lookup), SRC_REG (register port).
//   Default widths: 8-bit address (256 entries), 48-bit data.
package lut_bram_arb_pkg;
   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_DATA_WIDTH = 48;
   localparam logic [2:0] IDLE    = 3'b001;
   localparam logic [2:0] WR_HOLD = 3'b010;
   localparam logic [2:0] RD_WAIT = 3'b100;
   localparam logic SRC_LU  = 1'b0;
   localparam logic SRC_REG = 1'b1;
   typedef struct packed {
      logic valid;
      logic src;
   } pipe_t;
endpackage

// File: rtl/lut_bram_arb_rd_pipe.sv
// lut_bram_arb_rd_pipe: tracks in-flight BRAM reads and steers bram_dout to the owner.
//   clk, reset_n            : clock, asynchronous active-low reset (flushes in-flight reads)
//   issue_valid, issue_src  : read presented to the BRAM this cycle and who issued it
//   bram_dout               : BRAM read data, valid RD_LAT cycles after issue
//   lu_valid, lu_data       : lookup result pulse and data
//   rd_valid, rd_data       : register read pulse; rd_data holds until the next register read
module lut_bram_arb_rd_pipe
   import lut_bram_arb_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int RD_LAT     = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  issue_valid,
   input  logic                  issue_src,
   input  logic [DATA_WIDTH-1:0] bram_dout,
   output logic                  lu_valid,
   output logic [DATA_WIDTH-1:0] lu_data,
   output logic                  rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data
);
   pipe_t pipe [RD_LAT];
   logic [DATA_WIDTH-1:0] rd_hold;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
         rd_hold <= '0;
      end else begin
         pipe[0] <= '{valid: issue_valid, src: issue_src};
         for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
         if (rd_valid) rd_hold <= bram_dout;
      end
   end
   assign lu_valid = pipe[RD_LAT-1].valid && pipe[RD_LAT-1].src == SRC_LU;
   assign rd_valid = pipe[RD_LAT-1].valid && pipe[RD_LAT-1].src == SRC_REG;
   assign lu_data  = lu_valid ? bram_dout : '0;
   // register data is presented in its return cycle and held afterwards
   assign rd_data  = rd_valid ? bram_dout : rd_hold;
endmodule

// File: rtl/lut_bram_arbiter.sv
// lut_bram_arbiter: arbitrates a single-port label-LUT BRAM between datapath lookups and the CPU register port.
//   clk, reset_n                      : clock, asynchronous active-low reset
//   lu_req/lu_addr/lu_gnt             : lookup request, address, combinational grant (high priority)
//   lu_valid/lu_data                  : lookup result
//   wr_req/wr_addr/wr_data/wr_ack     : register write handshake
//   rd_req/rd_addr/rd_ack             : register read handshake
//   rd_valid/rd_data                  : register read result
//   bram_en/bram_we/bram_addr/bram_din/bram_dout : BRAM pins (controls registered)
//   Optional LUT_BRAM_ARB_STATS_EN adds stat_lu_cnt, stat_reg_cnt, stat_starve_cnt (saturating).
module lut_bram_arbiter
   import lut_bram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int RD_LAT       = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  lu_req,
   input  logic [ADDR_WIDTH-1:0] lu_addr,
   output logic                  lu_gnt,
   output logic                  lu_valid,
   output logic [DATA_WIDTH-1:0] lu_data,
   input  logic                  wr_req,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_ack,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_ack,
   output logic                  rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  bram_en,
   output logic                  bram_we,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic [DATA_WIDTH-1:0] bram_din,
   input  logic [DATA_WIDTH-1:0] bram_dout
`ifdef LUT_BRAM_ARB_STATS_EN
   ,
   output logic [31:0]           stat_lu_cnt,
   output logic [15:0]           stat_reg_cnt,
   output logic [15:0]           stat_starve_cnt
`endif
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   logic [2:0]    state;
   logic [SW-1:0] starve_cnt;
   logic          idle, reg_pend, reg_gnt, wr_gnt, rd_gnt, bram_src;
   assign idle     = state == IDLE;
   assign reg_pend = wr_req || rd_req;
   // the register port only wins when the lookup side is quiet or it has been starved long enough
   assign reg_gnt  = idle && reg_pend && (!lu_req || starve_cnt == STARVE_MAX);
   assign wr_gnt   = reg_gnt && wr_req;
   assign rd_gnt   = reg_gnt && !wr_req;
   assign lu_gnt   = lu_req && !reg_gnt;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         starve_cnt <= '0;
         bram_en    <= 1'b0;
         bram_we    <= 1'b0;
         bram_addr  <= '0;
         bram_din   <= '0;
         bram_src   <= SRC_LU;
         wr_ack     <= 1'b0;
         rd_ack     <= 1'b0;
      end else begin
         // WR_HOLD swallows the cycle where upstream still shows the acknowledged wr_req
         state      <= wr_gnt ? WR_HOLD : rd_gnt ? RD_WAIT : (state == RD_WAIT && !rd_valid) ? RD_WAIT : IDLE;
         starve_cnt <= reg_gnt ? '0 : (idle && reg_pend && lu_gnt && starve_cnt != STARVE_MAX) ? starve_cnt + SW'(1) : starve_cnt;
         bram_en    <= lu_gnt || reg_gnt;
         bram_we    <= wr_gnt;
         bram_addr  <= wr_gnt ? wr_addr : rd_gnt ? rd_addr : lu_addr;
         bram_din   <= wr_gnt ? wr_data : bram_din;
         bram_src   <= reg_gnt ? SRC_REG : SRC_LU;
         wr_ack     <= wr_gnt;
         rd_ack     <= rd_gnt;
      end
   end
   lut_bram_arb_rd_pipe #(
      .DATA_WIDTH(DATA_WIDTH),
      .RD_LAT    (RD_LAT)
   ) u_rd_pipe (
      .clk        (clk),
      .reset_n    (reset_n),
      .issue_valid(bram_en && !bram_we),
      .issue_src  (bram_src),
      .bram_dout  (bram_dout),
      .lu_valid   (lu_valid),
      .lu_data    (lu_data),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data)
   );
`ifdef LUT_BRAM_ARB_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_lu_cnt     <= '0;
         stat_reg_cnt    <= '0;
         stat_starve_cnt <= '0;
      end else begin
         stat_lu_cnt     <= stat_lu_cnt + 32'(lu_gnt && stat_lu_cnt != '1);
         stat_reg_cnt    <= stat_reg_cnt + 16'(reg_gnt && stat_reg_cnt != '1);
         stat_starve_cnt <= stat_starve_cnt + 16'(reg_gnt && lu_req && stat_starve_cnt != '1);
      end
   end
`endif
endmodule
